// File: rtl/pwm_ramp_ctrl.sv
// PWM duty-cycle sequencer: accepts duty targets over valid/ready, ramps the timer
// compare value in bounded steps at period boundaries, and performs a soft stop.
module pwm_ramp_ctrl #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_duty,
  input  logic [DW-1:0] cmd_step,
  input  logic          stop,
  input  logic          period_end,
  output logic [DW-1:0] duty_o,
  output logic          pwm_en_o,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_tgt;
  logic [DW-1:0] r_stp;
  logic [DW-1:0] r_duty;
  logic          r_en;
  logic          r_done;
  // Set once a soft stop has completed while stop is still held; blocks re-entry.
  logic          r_stopped;

  logic [DW-1:0] w_tgt_nxt;
  logic [DW-1:0] w_stp_nxt;
  logic [DW-1:0] w_duty_nxt;
  logic          w_en_nxt;
  logic          w_done_nxt;
  logic          w_stopped_nxt;
  logic          w_cmd_ready;
  logic [DW-1:0] w_step_val;
  logic          w_step_last;

  function automatic logic [DW:0] f_abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW:0] v;
    v = $signed({1'b0, a}) - $signed({1'b0, b});
    return (v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  // True when the next step lands exactly on the target (jump mode or within one step).
  function automatic logic f_last(input logic [DW-1:0] duty, input logic [DW-1:0] tgt,
                                  input logic [DW-1:0] stp);
    return (stp == '0) || (f_abs_diff(tgt, duty) <= {1'b0, stp});
  endfunction

  // Clamping to the target here is what keeps the result from wrapping past 0 or full scale.
  function automatic logic [DW-1:0] f_step(input logic [DW-1:0] duty, input logic [DW-1:0] tgt,
                                           input logic [DW-1:0] stp);
    logic [DW:0] sum;
    sum = '0;
    if (f_last(duty, tgt, stp)) begin
      return tgt;
    end
    if (tgt > duty) begin
      sum = {1'b0, duty} + {1'b0, stp};
    end else begin
      sum = {1'b0, duty} - {1'b0, stp};
    end
    return sum[DW-1:0];
  endfunction

  assign w_step_val  = f_step(r_duty, r_tgt, r_stp);
  assign w_step_last = f_last(r_duty, r_tgt, r_stp);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tgt_nxt     = r_tgt;
    w_stp_nxt     = r_stp;
    w_duty_nxt    = r_duty;
    w_en_nxt      = r_en;
    w_done_nxt    = 1'b0;
    w_stopped_nxt = r_stopped & stop;
    w_cmd_ready   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_cmd_ready = ~stop;
        if (stop) begin
          if (!r_stopped) begin
            w_tgt_nxt   = '0;
            w_state_nxt = S_STOP;
          end
        end else if (cmd_valid) begin
          w_tgt_nxt = cmd_duty;
          w_stp_nxt = cmd_step;
          w_en_nxt  = 1'b1;
          if (cmd_duty == r_duty) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_RAMP;
          end
        end
      end

      S_RAMP: begin
        if (stop) begin
          w_tgt_nxt   = '0;
          w_state_nxt = S_STOP;
        end else if (period_end) begin
          w_duty_nxt = w_step_val;
          if (w_step_last) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_STOP: begin
        if ((r_duty == '0) || (period_end && w_step_last)) begin
          w_duty_nxt    = '0;
          w_en_nxt      = 1'b0;
          w_done_nxt    = 1'b1;
          w_stopped_nxt = stop;
          w_state_nxt   = S_IDLE;
        end else if (period_end) begin
          w_duty_nxt = w_step_val;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tgt     <= '0;
      r_stp     <= '0;
      r_duty    <= '0;
      r_en      <= 1'b0;
      r_done    <= 1'b0;
      r_stopped <= 1'b0;
    end else begin
      r_tgt     <= w_tgt_nxt;
      r_stp     <= w_stp_nxt;
      r_duty    <= w_duty_nxt;
      r_en      <= w_en_nxt;
      r_done    <= w_done_nxt;
      r_stopped <= w_stopped_nxt;
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign duty_o    = r_duty;
  assign pwm_en_o  = r_en;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: scoreboard of expected duty updates
// plus per-scenario inline checks of control outputs.
module tb_pwm_ramp_ctrl;

  localparam int DW = 8;

  logic          CLK;
  logic          RST;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_duty;
  logic [DW-1:0] cmd_step;
  logic          stop;
  logic          period_end;
  logic [DW-1:0] duty_o;
  logic          pwm_en_o;
  logic          busy;
  logic          done;

  typedef struct {
    logic [DW-1:0] duty;
    logic          dn;
    logic          en;
  } exp_t;

  exp_t          exp_q[$];
  int            n_total;
  int            n_pass;
  logic [DW-1:0] prev_duty;

  pwm_ramp_ctrl #(.DW(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_duty   (cmd_duty),
    .cmd_step   (cmd_step),
    .stop       (stop),
    .period_end (period_end),
    .duty_o     (duty_o),
    .pwm_en_o   (pwm_en_o),
    .busy       (busy),
    .done       (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard: every change of duty_o must match the next queued expectation.
  always @(negedge CLK) begin
    if (RST) begin
      prev_duty = duty_o;
    end else if (duty_o !== prev_duty) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: duty_o changed %0d -> %0d, required no change", prev_duty, duty_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({duty_o, done, pwm_en_o} !== {e.duty, e.dn, e.en}) begin
          $display("FAIL sb_step: duty/done/en = %0d/%0d/%0d, required %0d/%0d/%0d",
                   duty_o, done, pwm_en_o, e.duty, e.dn, e.en);
        end else begin
          n_pass++;
        end
      end
      prev_duty = duty_o;
    end
  end

  task automatic push_exp(input logic [DW-1:0] d, input logic dn, input logic en);
    exp_t e;
    e.duty = d;
    e.dn   = dn;
    e.en   = en;
    exp_q.push_back(e);
  endtask

  task automatic pulse_pe();
    period_end = 1'b1;
    @(negedge CLK);
    period_end = 1'b0;
    @(negedge CLK);
  endtask

  task automatic send_cmd(input logic [DW-1:0] d, input logic [DW-1:0] s);
    logic ok;
    ok = 1'b0;
    cmd_duty  = d;
    cmd_step  = s;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    cmd_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL send_timeout: cmd_ready=%0d after 20 cycles, required 1", cmd_ready);
    end
  endtask

  task automatic test_reset();
    n_total++;
    if ({duty_o, pwm_en_o, done, busy, cmd_ready} !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      $display("FAIL reset_vals: duty/en/done/busy/rdy=%0d/%0d/%0d/%0d/%0d, required 0/0/0/0/1",
               duty_o, pwm_en_o, done, busy, cmd_ready);
    end else n_pass++;
    send_cmd(8'd100, 8'd30);
    push_exp(8'd30, 1'b0, 1'b1);
    push_exp(8'd60, 1'b0, 1'b1);
    pulse_pe();
    pulse_pe();
    n_total++;
    if (duty_o !== 8'd60) $display("FAIL reset_pre: duty_o=%0d, required 60", duty_o);
    else n_pass++;
    #2 RST = 1'b1;
    #1;
    n_total++;
    if ({duty_o, pwm_en_o, done, busy} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_async: duty/en/done/busy=%0d/%0d/%0d/%0d, required 0/0/0/0",
               duty_o, pwm_en_o, done, busy);
    end else n_pass++;
    @(negedge CLK);
    @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    n_total++;
    if ({cmd_ready, duty_o, busy} !== {1'b1, 8'd0, 1'b0}) begin
      $display("FAIL reset_release: rdy/duty/busy=%0d/%0d/%0d, required 1/0/0", cmd_ready, duty_o, busy);
    end else n_pass++;
  endtask

  task automatic test_up_ramp();
    cmd_duty   = 8'd100;
    cmd_step   = 8'd30;
    cmd_valid  = 1'b1;
    period_end = 1'b1;
    @(negedge CLK);
    cmd_valid  = 1'b0;
    period_end = 1'b0;
    n_total++;
    if ({duty_o, busy} !== {8'd0, 1'b1}) begin
      $display("FAIL accept_pe: duty/busy=%0d/%0d, required 0/1", duty_o, busy);
    end else n_pass++;
    push_exp(8'd30, 1'b0, 1'b1);
    push_exp(8'd60, 1'b0, 1'b1);
    push_exp(8'd90, 1'b0, 1'b1);
    push_exp(8'd100, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) pulse_pe();
    n_total++;
    if ({busy, pwm_en_o, done, duty_o} !== {1'b0, 1'b1, 1'b0, 8'd100}) begin
      $display("FAIL up_end: busy/en/done/duty=%0d/%0d/%0d/%0d, required 0/1/0/100",
               busy, pwm_en_o, done, duty_o);
    end else n_pass++;
  endtask

  task automatic test_down_jump();
    send_cmd(8'd10, 8'd50);
    push_exp(8'd50, 1'b0, 1'b1);
    push_exp(8'd10, 1'b1, 1'b1);
    pulse_pe();
    pulse_pe();
    send_cmd(8'd200, 8'd0);
    push_exp(8'd200, 1'b1, 1'b1);
    pulse_pe();
    n_total++;
    if (exp_q.size() != 0 || duty_o !== 8'd200) begin
      $display("FAIL down_jump: duty_o=%0d pending=%0d, required 200/0", duty_o, exp_q.size());
    end else n_pass++;
  endtask

  task automatic test_saturation();
    send_cmd(8'd250, 8'd0);
    push_exp(8'd250, 1'b1, 1'b1);
    pulse_pe();
    send_cmd(8'd255, 8'd200);
    push_exp(8'd255, 1'b1, 1'b1);
    pulse_pe();
    send_cmd(8'd5, 8'd0);
    push_exp(8'd5, 1'b1, 1'b1);
    pulse_pe();
    send_cmd(8'd0, 8'd200);
    push_exp(8'd0, 1'b1, 1'b1);
    pulse_pe();
    n_total++;
    if ({duty_o, pwm_en_o, busy} !== {8'd0, 1'b1, 1'b0} || exp_q.size() != 0) begin
      $display("FAIL sat_low: duty/en/busy=%0d/%0d/%0d, required 0/1/0", duty_o, pwm_en_o, busy);
    end else n_pass++;
  endtask

  task automatic test_soft_stop();
    int n_done;
    send_cmd(8'd200, 8'd100);
    push_exp(8'd100, 1'b0, 1'b1);
    push_exp(8'd200, 1'b1, 1'b1);
    pulse_pe();
    pulse_pe();
    stop = 1'b1;
    @(negedge CLK);
    n_total++;
    if ({busy, cmd_ready, duty_o} !== {1'b1, 1'b0, 8'd200}) begin
      $display("FAIL stop_enter: busy/rdy/duty=%0d/%0d/%0d, required 1/0/200", busy, cmd_ready, duty_o);
    end else n_pass++;
    push_exp(8'd100, 1'b0, 1'b1);
    push_exp(8'd0, 1'b1, 1'b0);
    pulse_pe();
    pulse_pe();
    n_done = 0;
    cmd_duty  = 8'd50;
    cmd_step  = 8'd0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (done) n_done++;
    end
    n_total++;
    if ({n_done[0], pwm_en_o, busy, cmd_ready, duty_o} !== {1'b0, 1'b0, 1'b0, 1'b0, 8'd0} || n_done != 0) begin
      $display("FAIL stop_hold: dones=%0d en/busy/rdy/duty=%0d/%0d/%0d/%0d, required 0 0/0/0/0",
               n_done, pwm_en_o, busy, cmd_ready, duty_o);
    end else n_pass++;
    stop = 1'b0;
    push_exp(8'd50, 1'b1, 1'b1);
    @(negedge CLK);
    cmd_valid = 1'b0;
    n_total++;
    if ({busy, pwm_en_o} !== {1'b1, 1'b1}) begin
      $display("FAIL stop_pending: busy/en=%0d/%0d, required 1/1", busy, pwm_en_o);
    end else n_pass++;
    pulse_pe();
  endtask

  task automatic test_equal();
    cmd_duty  = 8'd50;
    cmd_step  = 8'd7;
    cmd_valid = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    n_total++;
    if ({done, busy, duty_o} !== {1'b1, 1'b0, 8'd50}) begin
      $display("FAIL equal_done: done/busy/duty=%0d/%0d/%0d, required 1/0/50", done, busy, duty_o);
    end else n_pass++;
    @(negedge CLK);
    n_total++;
    if (done !== 1'b0) $display("FAIL equal_once: done=%0d, required 0", done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    cmd_duty  = 8'd80;
    cmd_step  = 8'd0;
    cmd_valid = 1'b1;
    push_exp(8'd80, 1'b1, 1'b1);
    @(negedge CLK);
    cmd_duty   = 8'd20;
    period_end = 1'b1;
    n_total++;
    if (cmd_ready !== 1'b0) $display("FAIL b2b_busy: cmd_ready=%0d, required 0", cmd_ready);
    else n_pass++;
    @(negedge CLK);
    period_end = 1'b0;
    n_total++;
    if ({cmd_ready, done} !== {1'b1, 1'b1}) begin
      $display("FAIL b2b_ready: rdy/done=%0d/%0d, required 1/1", cmd_ready, done);
    end else n_pass++;
    push_exp(8'd20, 1'b1, 1'b1);
    @(negedge CLK);
    cmd_valid = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%0d, required 1", busy);
    else n_pass++;
    pulse_pe();
    n_total++;
    if (exp_q.size() != 0 || duty_o !== 8'd20) begin
      $display("FAIL b2b_end: duty_o=%0d pending=%0d, required 20/0", duty_o, exp_q.size());
    end else n_pass++;
  endtask

  initial begin
    n_total    = 0;
    n_pass     = 0;
    prev_duty  = '0;
    RST        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_duty   = '0;
    cmd_step   = '0;
    stop       = 1'b0;
    period_end = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    test_reset();
    test_up_ramp();
    test_down_jump();
    test_saturation();
    test_soft_stop();
    test_equal();
    test_back_to_back();
    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Duty-cycle sequencer for the PWM timer. It accepts duty-cycle commands over a valid/ready handshake. It then moves the timer's compare value toward each target in bounded steps, updating only at PWM period boundaries so the motor drive never sees a mid-period glitch. It also performs a controlled soft stop, ramping to zero and then deasserting the timer enable. It sits between the odometry/motor control logic and the PWM timer, in the same `CLK` domain.

## Interface
- `DW`, 8, duty/compare width; matches the timer counter width.

- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_duty`  in  DW  target duty (compare value).
- `cmd_step`  in  DW  maximum duty change per PWM period; 0 = jump to target at the next boundary.
- `stop`  in  1  level; request a soft stop (ramp to 0, then disable).
- `period_end`  in  1  one-`CLK` pulse from the timer when its counter wraps.
- `duty_o`  out  DW  compare value driven to the timer.
- `pwm_en_o`  out  1  timer output enable.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when `duty_o` reaches the target.

## Operation
- States: IDLE, RAMP, STOP. Registers: `tgt[DW]`, `stp[DW]`, `duty_o`, `pwm_en_o`.
- IDLE:
  - `cmd_ready = ~stop`.
  - On `cmd_valid & cmd_ready`: `tgt <= cmd_duty`, `stp <= cmd_step`, `pwm_en_o <= 1`.
    - If `cmd_duty == duty_o`: stay IDLE and pulse `done` next cycle.
    - Otherwise go to RAMP.
  - On `stop` (any `pwm_en_o`): `tgt <= 0`, go to STOP; `stp` keeps its last value.
- RAMP: `cmd_ready = 0`.
  - On `period_end`, with `d = |tgt - duty_o|`:
    - If `stp == 0` or `d <= stp`: `duty_o <= tgt`, `done <= 1`, go to IDLE.
    - Else: `duty_o <= duty_o ± stp`, moving toward `tgt`.
  - `stop` high: `tgt <= 0` and go to STOP. No duty change in that cycle, even if `period_end` is high.
- STOP: same step rule as RAMP with `tgt = 0`.
  - On reaching 0: `duty_o <= 0`, `pwm_en_o <= 0`, `done <= 1`, go to IDLE.
  - If `duty_o` is already 0 on entry: complete at the next cycle, without waiting for `period_end`.
- Arithmetic:
  - Compare and add in `DW+1` bits.
  - The step result is clamped to `tgt`, so it never overshoots and never wraps past 0 or `2^DW-1`.
- Priority per cycle: `RST` > `stop` > `cmd_valid`. A command presented while `stop` is high is not accepted and stays pending.
- `stop` held high after STOP completes: remain IDLE with `cmd_ready = 0` and `pwm_en_o = 0`. No repeated `done`.
- `busy = (state != IDLE)`, decoded from the state register.

## Timing
- Reset values:
  - `duty_o = 0`, `pwm_en_o = 0`, `done = 0`, `busy = 0`.
  - `cmd_ready = 1` (when `stop = 0`), state IDLE, `tgt = 0`, `stp = 0`.
- Reset mid-operation aborts immediately (asynchronously) to the reset values. The in-flight command is discarded.
- Acceptance edge N: RAMP/STOP is visible from N+1. A `period_end` in cycle N itself is ignored; the first step occurs on the next `period_end`.
- `period_end` high in cycle k: the new `duty_o` is visible in cycle k+1. `done` and the IDLE state are visible in the same cycle as the final `duty_o`.
- `done` lasts exactly one cycle. `cmd_ready` rises in the cycle `done` is high, so a back-to-back command is accepted on that edge.
- `duty_o` changes only on `period_end`, except for reset.
- `pwm_en_o` rises at the acceptance edge and falls together with `duty_o` reaching 0 at the end of STOP.
- `period_end` pulses are at most one per timer period. Consecutive-cycle pulses are still each honoured as separate steps.

## Test plan
- Reset: assert `RST` mid-ramp at `duty_o = 60` -> all outputs at reset values immediately; after release `cmd_ready = 1`, `duty_o = 0`.
- Up ramp: from 0, cmd `duty = 100`, `step = 30`, four `period_end` pulses -> `duty_o` 30, 60, 90, 100; `done` coincides with 100; `busy` falls; `pwm_en_o = 1`.
- Down ramp and jump:
  - From 100, `duty = 10`, `step = 50` -> 50, then 10.
  - Then `duty = 200`, `step = 0` -> 200 after one `period_end`.
- Saturation:
  - From 250, `duty = 255`, `step = 200` -> 255.
  - From 5, `duty = 0`, `step = 200` -> 0; no wrap.
- Soft stop:
  - At `duty_o = 200` with `stp = 100`, raise `stop` -> 100, 0; `pwm_en_o` falls with 0; one `done`.
  - `stop` asserted together with `cmd_valid` in IDLE -> command not accepted.
- Edge timing:
  - `period_end` coincident with acceptance -> no step that cycle.
  - Command equal to current duty -> `done` next cycle, state stays IDLE.
